// File: rtl/dma_master.sv
// -----------------------------------------------------------------------------
// dma_master
// Block-copy bus master for the shared Z80-style bus. It requests the bus with
// busrq_n, waits for busack_n, then copies `length` bytes from src_addr to
// dst_addr with one mreq_n read cycle and one mreq_n write cycle per byte.
// It stretches either cycle while buswait_n is low and gives the bus back when
// the block is finished.
//
// State table:
//   IDLE | bus released, waiting for start
//   REQ  | busrq_n low, waiting for busack_n
//   RD   | memory read from src, buffer loads on the ending edge
//   WR   | memory write of the buffer to dst
//   REL  | one cycle with strobes inactive before the bus is released
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start             command pulse, accepted in IDLE only
//   src_addr/dst_addr first source / destination address, latched on start
//   length            byte count, latched on start (0 -> immediate done)
//   busy, done        busy while not IDLE; one-cycle done pulse
//   busrq_n/busack_n  bus request (open-drain) / grant
//   iorq_n, mreq_n, rd_n, wr_n, addr
//                     bus strobes and address, Z unless this block owns the bus
//   data              bus data, driven only in WR while owning
//   buswait_n         wait request from the addressed peripheral
// -----------------------------------------------------------------------------
module dma_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  busrq_n,
    input  logic                  busack_n,
    output logic                  iorq_n,
    output logic                  mreq_n,
    output logic                  rd_n,
    output logic                  wr_n,
    output logic [ADDR_WIDTH-1:0] addr,
    inout  logic [DATA_WIDTH-1:0] data,
    input  logic                  buswait_n
);

    typedef enum logic [2:0] {IDLE, REQ, RD, WR, REL} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, dst_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] buf_q;
    logic                  done_q, done_d;

    logic                  load, capture, advance;
    logic                  req_v, mreq_v, rd_v, wr_v, own;
    logic [ADDR_WIDTH-1:0] addr_v;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        load    = 1'b0;
        capture = 1'b0;
        advance = 1'b0;
        req_v   = 1'b0;
        mreq_v  = 1'b1;
        rd_v    = 1'b1;
        wr_v    = 1'b1;
        // REL keeps pointing at the byte just written; dst_q has already moved on.
        addr_v  = dst_q - ADDR_WIDTH'(1);
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        load    = 1'b1;
                        state_d = REQ;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            REQ: begin
                req_v = 1'b1;
                if (!busack_n) state_d = RD;
            end
            RD: begin
                req_v  = 1'b1;
                mreq_v = 1'b0;
                rd_v   = 1'b0;
                addr_v = src_q;
                // Losing the grant wins over a completing read: the element restarts.
                if (busack_n) begin
                    state_d = REQ;
                end else if (buswait_n) begin
                    capture = 1'b1;
                    state_d = WR;
                end
            end
            WR: begin
                req_v  = 1'b1;
                mreq_v = 1'b0;
                wr_v   = 1'b0;
                addr_v = dst_q;
                if (busack_n) begin
                    state_d = REQ;
                end else if (buswait_n) begin
                    advance = 1'b1;
                    state_d = (cnt_q == LEN_WIDTH'(1)) ? REL : RD;
                end
            end
            REL: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q  <= '0;
            dst_q  <= '0;
            cnt_q  <= '0;
            buf_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
            if (load) begin
                src_q <= src_addr;
                dst_q <= dst_addr;
                cnt_q <= length;
            end
            if (capture) buf_q <= data;
            if (advance) begin
                src_q <= src_q + ADDR_WIDTH'(1);
                dst_q <= dst_q + ADDR_WIDTH'(1);
                cnt_q <= cnt_q - LEN_WIDTH'(1);
            end
        end
    end

    // Ownership follows the grant combinationally so a withdrawn busack_n
    // releases every driver in the same cycle.
    assign own = ((state_q == RD) || (state_q == WR) || (state_q == REL)) && !busack_n;

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign busrq_n = req_v ? 1'b0 : 1'bz;
    assign iorq_n  = own ? 1'b1   : 1'bz;
    assign mreq_n  = own ? mreq_v : 1'bz;
    assign rd_n    = own ? rd_v   : 1'bz;
    assign wr_n    = own ? wr_v   : 1'bz;
    assign addr    = own ? addr_v : {ADDR_WIDTH{1'bz}};
    assign data    = (own && (state_q == WR)) ? buf_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_dma_master.sv
// -----------------------------------------------------------------------------
// tb_dma_master
// Directed bench for dma_master. A CPU model grants the bus as soon as busrq_n
// falls (while grant_en is set). Source memory answers reads combinationally;
// completed write cycles land in a separate destination memory. Pullups model
// the board terminations, so a released bus line reads as 1.
// -----------------------------------------------------------------------------
module tb_dma_master;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] length = '0;
    logic          busy, done;
    wire           busrq_n, busack_n, iorq_n, mreq_n, rd_n, wr_n, buswait_n;
    wire  [AW-1:0] addr;
    wire  [DW-1:0] data;

    logic          grant_en = 1'b1;
    logic          wait_en = 1'b0;
    logic [DW-1:0] src_mem [0:65535];
    logic [DW-1:0] dst_mem [0:65535];
    int            wr_cnt = 0;
    int            done_cnt = 0, mreq_cnt = 0, busrq_cnt = 0, act_cnt = 0, wr_total = 0;
    int            checks = 0, errors = 0;

    pullup (busrq_n);
    pullup (iorq_n);
    pullup (mreq_n);
    pullup (rd_n);
    pullup (wr_n);
    pullup (addr);
    pullup (data);

    dma_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done),
        .busrq_n(busrq_n), .busack_n(busack_n),
        .iorq_n(iorq_n), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
        .addr(addr), .data(data), .buswait_n(buswait_n)
    );

    always #5 clk = ~clk;

    assign busack_n  = (grant_en && busrq_n === 1'b0) ? 1'b0 : 1'b1;
    assign data      = (mreq_n === 1'b0 && rd_n === 1'b0) ? src_mem[addr] : 8'hzz;
    // Slow peripheral: holds every write for its first two cycles.
    assign buswait_n = (wait_en && mreq_n === 1'b0 && wr_n === 1'b0 && wr_cnt < 2) ? 1'b0 : 1'b1;

    always @(posedge clk) begin
        if (done === 1'b1)    done_cnt  <= done_cnt + 1;
        if (mreq_n === 1'b0)  mreq_cnt  <= mreq_cnt + 1;
        if (busrq_n === 1'b0) busrq_cnt <= busrq_cnt + 1;
        if ({iorq_n, mreq_n, rd_n, wr_n} !== 4'hF) act_cnt <= act_cnt + 1;
        if (mreq_n === 1'b0 && wr_n === 1'b0 && buswait_n === 1'b1) begin
            dst_mem[addr] <= data;
            wr_total      <= wr_total + 1;
        end
        wr_cnt <= (mreq_n === 1'b0 && wr_n === 1'b0) ? wr_cnt + 1 : 0;
    end

    // Returns on the negedge following the edge that accepted start.
    task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        length   = n;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // k = negedge index (1 = first after start) where done is seen, -1 on timeout.
    task automatic wait_done(output int k);
        k = -1;
        for (int i = 1; i <= 200; i++) begin
            if (done === 1'b1) begin
                k = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got %b want 00", {busy, done}); end
        checks++; if ({busrq_n, iorq_n, mreq_n, rd_n, wr_n} !== 5'b11111) begin errors++; $display("FAIL reset_strobes got %b want 11111 (released)", {busrq_n, iorq_n, mreq_n, rd_n, wr_n}); end
        checks++; if (addr !== 16'hFFFF) begin errors++; $display("FAIL reset_addr got %h want ffff (released)", addr); end
        checks++; if (data !== 8'hFF) begin errors++; $display("FAIL reset_data got %h want ff (released)", data); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_copy();
        int k, d0, m0, w0;
        src_mem[16'h0000] = 8'h00;
        src_mem[16'h0001] = 8'h01;
        src_mem[16'h0002] = 8'h02;
        d0 = done_cnt; m0 = mreq_cnt; w0 = wr_total;
        do_start(16'h0000, 16'h8000, 8'd3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL copy_busy_rise got %b want 1", busy); end
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            if (done === 1'b1) begin
                k = i;
                break;
            end
            // A start pulse mid-transfer must be ignored.
            start  = (i == 3);
            length = 8'd9;
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (k !== 9) begin errors++; $display("FAIL copy_latency got %0d want 9", k); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL copy_busy_at_done got %b want 0", busy); end
        checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL copy_busrq_released got %b want 1", busrq_n); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL copy_done_width got %b want 0", done); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL copy_done_count got %0d want 1", done_cnt - d0); end
        checks++; if (mreq_cnt - m0 !== 6) begin errors++; $display("FAIL copy_bus_cycles got %0d want 6", mreq_cnt - m0); end
        checks++; if (wr_total - w0 !== 3) begin errors++; $display("FAIL copy_writes got %0d want 3", wr_total - w0); end
        checks++; if ({dst_mem[16'h8000], dst_mem[16'h8001], dst_mem[16'h8002]} !== 24'h000102) begin
            errors++; $display("FAIL copy_data got %h%h%h want 000102", dst_mem[16'h8000], dst_mem[16'h8001], dst_mem[16'h8002]);
        end
    endtask

    task automatic test_wait();
        int k, wr_cycles, d0;
        src_mem[16'h0001] = 8'h5A;
        wait_en = 1'b1;
        d0 = done_cnt;
        wr_cycles = 0;
        do_start(16'h0001, 16'h8001, 8'd1);
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            if (done === 1'b1) begin
                k = i;
                break;
            end
            if (wr_n === 1'b0) begin
                wr_cycles++;
                checks++; if ({addr, data} !== {16'h8001, 8'h5A}) begin errors++; $display("FAIL wait_hold got %h/%h want 8001/5a", addr, data); end
            end
            @(negedge clk);
        end
        wait_en = 1'b0;
        checks++; if (wr_cycles !== 3) begin errors++; $display("FAIL wait_wr_cycles got %0d want 3", wr_cycles); end
        checks++; if (k !== 7) begin errors++; $display("FAIL wait_latency got %0d want 7", k); end
        checks++; if (dst_mem[16'h8001] !== 8'h5A) begin errors++; $display("FAIL wait_data got %h want 5a", dst_mem[16'h8001]); end
        @(negedge clk);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL wait_done_count got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_zero_len();
        int d0, b0, a0;
        d0 = done_cnt; b0 = busrq_cnt; a0 = act_cnt;
        do_start(16'h4000, 16'hC000, 8'd0);
        checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL zero_done_busy got %b want 10", {done, busy}); end
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width got %b want 0", done); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL zero_done_count got %0d want 1", done_cnt - d0); end
        checks++; if (busrq_cnt - b0 !== 0) begin errors++; $display("FAIL zero_busrq got %0d low cycles want 0", busrq_cnt - b0); end
        checks++; if (act_cnt - a0 !== 0) begin errors++; $display("FAIL zero_strobes got %0d active cycles want 0", act_cnt - a0); end
    endtask

    task automatic test_wrap();
        int k;
        src_mem[16'hFFFF] = 8'hA1;
        src_mem[16'h0000] = 8'hB2;
        do_start(16'hFFFF, 16'h7FFF, 8'd2);
        wait_done(k);
        checks++; if (k <= 0) begin errors++; $display("FAIL wrap_src_timeout got %0d want done", k); end
        checks++; if ({dst_mem[16'h7FFF], dst_mem[16'h8000]} !== 16'hA1B2) begin
            errors++; $display("FAIL wrap_src_data got %h%h want a1b2", dst_mem[16'h7FFF], dst_mem[16'h8000]);
        end
        src_mem[16'h1000] = 8'hC3;
        src_mem[16'h1001] = 8'hD4;
        do_start(16'h1000, 16'hFFFF, 8'd2);
        wait_done(k);
        checks++; if (k <= 0) begin errors++; $display("FAIL wrap_dst_timeout got %0d want done", k); end
        checks++; if ({dst_mem[16'hFFFF], dst_mem[16'h0000]} !== 16'hC3D4) begin
            errors++; $display("FAIL wrap_dst_data got %h%h want c3d4", dst_mem[16'hFFFF], dst_mem[16'h0000]);
        end
    endtask

    task automatic test_grant_withdraw();
        int k, m0, w0;
        src_mem[16'h2000] = 8'h11;
        src_mem[16'h2001] = 8'h22;
        m0 = mreq_cnt; w0 = wr_total;
        do_start(16'h2000, 16'h9000, 8'd2);
        repeat (4) @(negedge clk);
        checks++; if ({wr_n, addr} !== {1'b0, 16'h9001}) begin errors++; $display("FAIL gw_second_wr got %b/%h want 0/9001", wr_n, addr); end
        grant_en = 1'b0;
        #1;
        checks++; if ({iorq_n, mreq_n, rd_n, wr_n} !== 4'hF) begin errors++; $display("FAIL gw_strobes_released got %b want 1111", {iorq_n, mreq_n, rd_n, wr_n}); end
        checks++; if ({addr, data} !== {16'hFFFF, 8'hFF}) begin errors++; $display("FAIL gw_bus_released got %h/%h want ffff/ff", addr, data); end
        // A new source value proves the element is re-read after regrant.
        src_mem[16'h2001] = 8'h33;
        @(negedge clk);
        checks++; if ({busy, busrq_n} !== 2'b10) begin errors++; $display("FAIL gw_back_to_req got %b want 10", {busy, busrq_n}); end
        checks++; if (wr_total - w0 !== 1) begin errors++; $display("FAIL gw_aborted_write got %0d writes want 1", wr_total - w0); end
        grant_en = 1'b1;
        wait_done(k);
        checks++; if (k <= 0) begin errors++; $display("FAIL gw_timeout got %0d want done", k); end
        checks++; if ({dst_mem[16'h9000], dst_mem[16'h9001]} !== 16'h1133) begin
            errors++; $display("FAIL gw_data got %h%h want 1133", dst_mem[16'h9000], dst_mem[16'h9001]);
        end
        checks++; if (wr_total - w0 !== 2) begin errors++; $display("FAIL gw_writes got %0d want 2", wr_total - w0); end
        checks++; if (mreq_cnt - m0 !== 5) begin errors++; $display("FAIL gw_bus_cycles got %0d want 5", mreq_cnt - m0); end
    endtask

    task automatic test_reset_mid();
        int k, w0;
        src_mem[16'h3000] = 8'h61;
        src_mem[16'h3001] = 8'h62;
        w0 = wr_total;
        do_start(16'h3000, 16'hA000, 8'd4);
        @(negedge clk);
        checks++; if ({mreq_n, rd_n, addr} !== {2'b00, 16'h3000}) begin errors++; $display("FAIL rst_mid_in_rd got %b%b/%h want 00/3000", mreq_n, rd_n, addr); end
        reset_n = 1'b0;
        #1;
        checks++; if ({busy, done, busrq_n} !== 3'b001) begin errors++; $display("FAIL rst_mid_ctrl got %b want 001", {busy, done, busrq_n}); end
        checks++; if ({iorq_n, mreq_n, rd_n, wr_n, addr} !== {4'hF, 16'hFFFF}) begin
            errors++; $display("FAIL rst_mid_bus got %b/%h want 1111/ffff", {iorq_n, mreq_n, rd_n, wr_n}, addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        checks++; if (wr_total - w0 !== 0) begin errors++; $display("FAIL rst_mid_no_write got %0d want 0", wr_total - w0); end
        do_start(16'h3000, 16'hB000, 8'd2);
        wait_done(k);
        checks++; if (k !== 7) begin errors++; $display("FAIL rst_mid_restart_latency got %0d want 7", k); end
        checks++; if ({dst_mem[16'hB000], dst_mem[16'hB001]} !== 16'h6162) begin
            errors++; $display("FAIL rst_mid_restart_data got %h%h want 6162", dst_mem[16'hB000], dst_mem[16'hB001]);
        end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_wait();
        test_zero_len();
        test_wrap();
        test_grant_withdraw();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dma_master.md
# dma_master

Bus-mastering block-copy engine for the shared 8-bit-data/16-bit-address Z80-style bus. It is the requesting end of the busrq_n/busack_n handshake: it asks the current master (cpu) for the bus, takes ownership on grant, and copies a block memory-to-memory with mreq_n read/write cycles. It honours buswait_n from slow peripherals, then releases the bus. Software or a local controller drives it through a start/busy/done command port.

## Interface
- DATA_WIDTH, 8, bus data width
- ADDR_WIDTH, 16, bus address width
- LEN_WIDTH, 8, width of transfer length (max 2^LEN_WIDTH-1 elements)

- clk  in  1  system clock, all state on posedge
- reset_n  in  1  one clock; reset is asynchronous and active-low
- start  in  1  single-cycle command pulse, sampled in IDLE only
- src_addr  in  ADDR_WIDTH  first source address, latched on start
- dst_addr  in  ADDR_WIDTH  first destination address, latched on start
- length  in  LEN_WIDTH  element count, latched on start
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- busrq_n  out  1  bus request, open-drain: 0 when requesting/owning, else Z
- busack_n  in  1  grant from current master, active low
- iorq_n, mreq_n, rd_n, wr_n  out  1 each  bus strobes, Z when not owning
- addr  out  ADDR_WIDTH  bus address, Z when not owning
- data  inout  DATA_WIDTH  driven only in WR while owning, else Z
- buswait_n  in  1  wait from addressed peripheral, active low

## Operation
- States: IDLE, REQ, RD, WR, REL.
- own = (state is RD, WR or REL) && !busack_n, combinational; gates every bus driver.
- Owning drive values: iorq_n=1; RD: mreq_n=0, rd_n=0, wr_n=1, addr=src; WR: mreq_n=0, rd_n=1, wr_n=0, addr=dst, data=buffer; REL: mreq_n=rd_n=wr_n=1, addr=last dst.
- IDLE: busrq_n=Z. start && length!=0: latch src/dst/length, busy=1, go REQ. start && length==0: done pulse next cycle, no bus activity, stay IDLE.
- REQ: busrq_n=0. busack_n==0 at posedge -> RD.
- RD: buswait_n==0 at posedge -> stay. Else capture data into buffer -> WR.
- WR: buswait_n==0 -> stay. Else src+=1, dst+=1, count-=1; count was 1 -> REL, else -> RD.
- REL: busrq_n=Z, strobes inactive for one cycle -> IDLE with done=1, busy=0.
- Grant withdrawn: busack_n==1 sampled in RD or WR -> REQ; counters and buffer unchanged, current element retried from its read. Drivers release combinationally.
- Addresses increment modulo 2^ADDR_WIDTH (0xFFFF -> 0x0000); no error.
- start while busy ignored.

## Timing
- Reset (async, immediate): state=IDLE, busy=0, done=0, busrq_n=Z, all bus outputs Z, counters 0.
- Reset mid-transfer: bus released in same delta; the partially copied block is not resumed.
- Latency, zero wait, grant in the same cycle busrq_n falls: start edge T0 -> REQ at T1; busack_n=0 at T1 edge -> RD at T2 -> WR at T3 -> ... For N elements: 2N bus cycles after grant, then REL, then done high for one cycle.
- Each wait cycle adds exactly one cycle to the stalled RD/WR; strobes, addr and data are held stable throughout.
- Read data is sampled at the posedge ending RD (buswait_n=1). The peripheral drives data combinationally from addr/rd_n.
- Write data is valid the whole WR state. Peripherals may latch it on either clock edge.
- done and busy deassertion coincide; busy=0 exactly when state=IDLE.

## Test plan
- Copy 3 bytes: mem0[0..2]=00,01,02, src 0x0000 -> dst 0x8000, immediate grant -> mem1[0..2]=00,01,02; done once, 6 bus cycles after grant; busrq_n Z after REL.
- Wait states: peripheral asserts buswait_n 2 cycles after each write, 1 byte 0x0001 -> 0x8001 -> WR held 2 extra cycles with stable addr/data; correct byte written; done once.
- length=0 with start -> done pulse next cycle, busrq_n never low, no strobe activity.
- Wrap: src=0xFFFF, length=2 -> reads 0xFFFF then 0x0000; dst increments likewise.
- Grant withdrawn: busack_n=1 during the second element's WR -> bus Z in same cycle, back to REQ; after regrant the second element is re-read and rewritten; final memory correct.
- Reset at mid-copy (RD state) -> all bus outputs Z, busrq_n Z, busy=0 immediately; new start after reset completes normally.
